// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with a byte-addressed little-endian data memory, the MEM/WB register and a debug read port.
// Optional MISALIGN_TRAP_EN adds a sticky o_misalign output and blocks misaligned accesses.
module mem_access_stage #(
    parameter int NB_DATA   = 32,
    parameter int MEM_DEPTH = 256,
    parameter int NB_ADDR   = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_halt,
    input  logic               i_mem2reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [4:0]         i_write_reg,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
`ifdef MISALIGN_TRAP_EN
    output logic               o_misalign,
`endif
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [4:0]         o_write_reg,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic [NB_DATA-1:0] o_dbg_data
);

    logic [7:0]         mem [MEM_DEPTH];
    logic [NB_ADDR-1:0] a0, a1, a2, a3;
    logic [NB_ADDR-1:0] d0, d1, d2, d3;
    logic [NB_DATA-1:0] rd_word, ld_data, dbg_word;
    logic               is_half, is_word, mis, st_en;
    logic               unused_dbg;

    assign unused_dbg = ^i_dbg_addr[1:0];

    // Lane addresses wrap modulo MEM_DEPTH through NB_ADDR-bit arithmetic
    assign a0 = i_result[NB_ADDR-1:0];
    assign a1 = a0 + NB_ADDR'(1);
    assign a2 = a0 + NB_ADDR'(2);
    assign a3 = a0 + NB_ADDR'(3);

    assign d0 = {i_dbg_addr[NB_ADDR-1:2], 2'b00};
    assign d1 = {i_dbg_addr[NB_ADDR-1:2], 2'b01};
    assign d2 = {i_dbg_addr[NB_ADDR-1:2], 2'b10};
    assign d3 = {i_dbg_addr[NB_ADDR-1:2], 2'b11};

    assign is_half = i_width == 2'b01;
    assign is_word = i_width[1];

`ifdef MISALIGN_TRAP_EN
    assign mis = (is_half & a0[0]) | (is_word & (|a0[1:0]));
`else
    assign mis = 1'b0;
`endif

    assign st_en    = i_memWrite & ~i_stall & ~i_halt & ~mis;
    assign rd_word  = {mem[a3], mem[a2], mem[a1], mem[a0]};
    assign dbg_word = {mem[d3], mem[d2], mem[d1], mem[d0]};

    always_comb begin
        ld_data = is_word ? rd_word :
                  is_half ? {{(NB_DATA-16){i_sign_flag & rd_word[15]}}, rd_word[15:0]} :
                            {{(NB_DATA-8){i_sign_flag & rd_word[7]}}, rd_word[7:0]};
    end

    // Memory contents survive reset, so the array has no reset branch
    always_ff @(posedge clk) begin
        if (st_en) begin
            mem[a0] <= i_data4Mem[7:0];
            if (is_half | is_word)
                mem[a1] <= i_data4Mem[15:8];
            if (is_word) begin
                mem[a2] <= i_data4Mem[23:16];
                mem[a3] <= i_data4Mem[31:24];
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem2reg    <= 1'b0;
            o_regWrite   <= 1'b0;
            o_write_reg  <= '0;
            o_read_data  <= '0;
            o_alu_result <= '0;
            o_dbg_data   <= '0;
        end else begin
            if (!i_stall) begin
                o_mem2reg    <= i_mem2reg;
                o_regWrite   <= i_regWrite & ~(i_memRead & mis);
                o_write_reg  <= i_write_reg;
                o_read_data  <= (i_memRead & ~mis) ? ld_data : '0;
                o_alu_result <= i_result;
            end
            if (i_halt)
                o_dbg_data <= dbg_word;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_misalign <= 1'b0;
        else if (!i_stall && mis && (i_memRead || (i_memWrite && !i_halt)))
            o_misalign <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vectors with hand-computed results for mem_access_stage.
module tb_mem_access_stage;

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n, stall, halt, m2r, mr, mw, rw, sg;
    logic [1:0]  width;
    logic [4:0]  wreg;
    logic [31:0] result, data;
    logic [7:0]  dbg_addr;
    logic        o_m2r, o_rw;
    logic [4:0]  o_wreg;
    logic [31:0] o_rd, o_alu, o_dbg;
`ifdef MISALIGN_TRAP_EN
    logic        o_mis;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_halt(halt),
        .i_mem2reg(m2r), .i_memRead(mr), .i_memWrite(mw), .i_regWrite(rw),
        .i_width(width), .i_sign_flag(sg), .i_write_reg(wreg),
        .i_result(result), .i_data4Mem(data), .i_dbg_addr(dbg_addr),
`ifdef MISALIGN_TRAP_EN
        .o_misalign(o_mis),
`endif
        .o_mem2reg(o_m2r), .o_regWrite(o_rw), .o_write_reg(o_wreg),
        .o_read_data(o_rd), .o_alu_result(o_alu), .o_dbg_data(o_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic op(input logic r, input logic w, input logic m, input logic g,
                      input logic [1:0] wd, input logic s, input logic [31:0] a,
                      input logic [31:0] d, input logic [4:0] dst);
        mr = r; mw = w; m2r = m; rw = g; width = wd; sg = s;
        result = a; data = d; wreg = dst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; halt = 1'b0; m2r = 1'b0; mr = 1'b0; mw = 1'b0;
        rw = 1'b0; sg = 1'b0; width = W; wreg = '0; result = '0; data = '0; dbg_addr = '0;
        #1;
        check("rst_rd", o_rd, 0);
        check("rst_alu", o_alu, 0);
        check("rst_dbg", o_dbg, 0);
        check("rst_rw", 32'(o_rw), 0);
        check("rst_m2r", 32'(o_m2r), 0);
        check("rst_wreg", 32'(o_wreg), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        op(0, 1, 0, 0, W, 0, 32'h10, 32'h12345678, 0);
        check("st_alu", o_alu, 32'h10);
        check("st_rd", o_rd, 0);
        check("st_rw", 32'(o_rw), 0);
        op(1, 0, 1, 1, W, 0, 32'h10, 0, 5);
        check("ldw", o_rd, 32'h12345678);
        check("ldw_m2r", 32'(o_m2r), 1);
        check("ldw_rw", 32'(o_rw), 1);
        check("ldw_wreg", 32'(o_wreg), 5);
        op(1, 0, 1, 1, B, 0, 32'h10, 0, 5);
        check("ldbu_10", o_rd, 32'h78);
        op(1, 0, 1, 1, B, 1, 32'h10, 0, 5);
        check("ldbs_10", o_rd, 32'h78);
        op(1, 0, 1, 1, H, 0, 32'h10, 0, 5);
        check("ldhu_10", o_rd, 32'h5678);
        op(1, 0, 1, 1, B, 0, 32'h11, 0, 5);
        check("ldbu_11", o_rd, 32'h56);

        op(0, 1, 0, 0, B, 0, 32'h21, 32'hAAAAAA80, 0);
        op(1, 0, 1, 1, B, 1, 32'h21, 0, 5);
        check("ldbs_21", o_rd, 32'hFFFFFF80);
        op(1, 0, 1, 1, B, 0, 32'h21, 0, 5);
        check("ldbu_21", o_rd, 32'h80);

        op(0, 1, 0, 0, H, 0, 32'h30, 32'h1234BEEF, 0);
        op(1, 0, 1, 1, H, 1, 32'h30, 0, 5);
        check("ldhs_30", o_rd, 32'hFFFFBEEF);
        op(1, 0, 1, 1, H, 0, 32'h30, 0, 5);
        check("ldhu_30", o_rd, 32'h0000BEEF);
        op(1, 0, 1, 1, 2'b10, 1, 32'h10, 0, 5);
        check("ldw_w10", o_rd, 32'h12345678);

        op(0, 1, 0, 0, W, 0, 32'h40, 32'h11111111, 0);
        op(1, 0, 1, 1, W, 0, 32'h10, 0, 7);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op(0, 1, 0, 0, W, 0, 32'h40, 32'h22222222, 0);
            check("stall_alu", o_alu, 32'h10);
            check("stall_rd", o_rd, 32'h12345678);
            check("stall_wreg", 32'(o_wreg), 7);
            check("stall_rw", 32'(o_rw), 1);
        end
        stall = 1'b0;
        op(1, 0, 1, 1, W, 0, 32'h40, 0, 3);
        check("stall_nowr", o_rd, 32'h11111111);
        op(0, 1, 0, 0, W, 0, 32'h40, 32'h22222222, 0);
        op(1, 0, 1, 1, W, 0, 32'h40, 0, 3);
        check("unstall_wr", o_rd, 32'h22222222);

        halt = 1'b1; dbg_addr = 8'h13;
        op(0, 1, 0, 0, W, 0, 32'h10, 32'hDEADBEEF, 0);
        check("halt_dbg", o_dbg, 32'h12345678);
        check("halt_alu", o_alu, 32'h10);
        halt = 1'b0; dbg_addr = 8'h40;
        op(1, 0, 1, 1, W, 0, 32'h10, 0, 2);
        check("halt_nowr", o_rd, 32'h12345678);
        check("dbg_hold", o_dbg, 32'h12345678);
        halt = 1'b1; dbg_addr = 8'h42;
        op(0, 0, 0, 0, W, 0, 0, 0, 0);
        check("dbg_40", o_dbg, 32'h22222222);
        halt = 1'b0;

        op(1, 1, 1, 1, W, 0, 32'h40, 32'h33333333, 4);
        check("rdwr_old", o_rd, 32'h22222222);
        op(1, 0, 1, 1, W, 0, 32'h40, 0, 4);
        check("rdwr_new", o_rd, 32'h33333333);

`ifndef MISALIGN_TRAP_EN
        op(0, 1, 0, 0, W, 0, 32'hFE, 32'hA1B2C3D4, 0);
        op(1, 0, 1, 1, H, 0, 32'h00, 0, 1);
        check("wrap_h00", o_rd, 32'hA1B2);
        op(1, 0, 1, 1, B, 0, 32'hFF, 0, 1);
        check("wrap_bff", o_rd, 32'hC3);
        op(1, 0, 1, 1, W, 0, 32'h1FE, 0, 1);
        check("wrap_w1fe", o_rd, 32'hA1B2C3D4);
        check("wrap_alu", o_alu, 32'h1FE);
`else
        op(0, 1, 0, 0, W, 0, 32'h12, 32'hFFFFFFFF, 0);
        check("mis_st_flag", 32'(o_mis), 1);
        op(1, 0, 1, 1, W, 0, 32'h10, 0, 1);
        check("mis_st_blk", o_rd, 32'h12345678);
        op(1, 0, 1, 1, W, 0, 32'h02, 0, 9);
        check("mis_ld_rd", o_rd, 0);
        check("mis_ld_rw", 32'(o_rw), 0);
        check("mis_flag", 32'(o_mis), 1);
`endif

        op(0, 0, 0, 1, W, 0, 32'h77, 0, 6);
        check("pre_rst_alu", o_alu, 32'h77);
        #1 rst_n = 1'b0;
        #1;
        check("arst_alu", o_alu, 0);
        check("arst_rw", 32'(o_rw), 0);
        check("arst_wreg", 32'(o_wreg), 0);
        check("arst_dbg", o_dbg, 0);
        check("arst_rd", o_rd, 0);
`ifdef MISALIGN_TRAP_EN
        check("arst_mis", 32'(o_mis), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        op(1, 0, 1, 1, W, 0, 32'h10, 0, 5);
        check("post_rst_w", o_rd, 32'h12345678);
        op(1, 0, 1, 1, B, 1, 32'h21, 0, 5);
        check("post_rst_b", o_rd, 32'hFFFFFF80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline; sits between the execute stage and writeback.
- Consumes the EX/MEM bundle: ALU result used as address, store data, mem control, width and sign flag, destination register.
- Contains the byte-addressed data memory and performs byte/half/word loads and stores with sign/zero extension.
- Registers the MEM/WB bundle; provides a debug read port for the debug unit while the pipeline is halted.

Parameters:
- NB_DATA, 32, data/address width.
- MEM_DEPTH, 256, data memory size in bytes; power of two, at least 4.
- NB_ADDR, 8, log2(MEM_DEPTH); index bits actually used.

Ports:
- clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_stall  in  1  hold MEM/WB register; suppress stores.
- i_halt  in  1  pipeline halted; suppress stores; enable debug reads.
- i_mem2reg  in  1  writeback selects memory data.
- i_memRead  in  1  load in this stage.
- i_memWrite  in  1  store in this stage.
- i_regWrite  in  1  instruction writes the register file.
- i_width  in  2  00 = byte, 01 = half, 11 = word, 10 = treated as word.
- i_sign_flag  in  1  1 = sign-extend loads, 0 = zero-extend.
- i_write_reg  in  5  destination register number.
- i_result  in  NB_DATA  ALU result (memory address or pass-through value).
- i_data4Mem  in  NB_DATA  store data.
- i_dbg_addr  in  NB_ADDR  debug byte address, word-aligned by the block.
- o_mem2reg  out  1  registered i_mem2reg.
- o_regWrite  out  1  registered i_regWrite.
- o_write_reg  out  5  registered i_write_reg.
- o_read_data  out  NB_DATA  registered extended load data.
- o_alu_result  out  NB_DATA  registered i_result, also the forwarding source.
- o_dbg_data  out  NB_DATA  registered debug word.

Behaviour:
- Reset (asynchronous, i_rst_n low): all outputs go to 0. Memory contents are not cleared.
- Memory layout:
  - byte array, little-endian;
  - address index is i_result[NB_ADDR-1:0], upper bits ignored, so addresses wrap modulo MEM_DEPTH.
- Store at posedge when i_memWrite & !i_stall & !i_halt:
  - byte: mem[a] <= d[7:0];
  - half: mem[a], mem[a+1] <= d[15:0] (low byte at a);
  - word: mem[a..a+3] <= d[31:0].
  - Indices a+1..a+3 wrap modulo MEM_DEPTH.
- Load: combinational read of mem[a..a+3] using the same lane rules, then extension:
  - byte: bit 7 replicated if i_sign_flag, else zeros;
  - half: bit 15 replicated if i_sign_flag, else zeros;
  - word: unchanged.
  - Captured into o_read_data at posedge when !i_stall. If i_memRead = 0, o_read_data captures 0.
- MEM/WB register:
  - o_mem2reg, o_regWrite, o_write_reg, o_alu_result update each posedge when !i_stall; latency 1 cycle.
  - While i_stall is high, all MEM/WB outputs hold their values.
- Halt:
  - i_halt blocks stores but does not freeze the MEM/WB register; the stall input freezes it.
  - Each posedge with i_halt = 1: o_dbg_data <= word at {i_dbg_addr[NB_ADDR-1:2], 2'b00}; latency 1 cycle.
  - o_dbg_data holds when i_halt = 0.
- Read-after-write:
  - a store at edge N is visible to a load evaluated after edge N;
  - a load and a store never coexist in one instruction; if both flags are set, the store occurs and the loaded data reflects the pre-store contents.
- Stall with memWrite: the store is suppressed for every stalled cycle and occurs exactly once, on the first unstalled edge.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - adds output o_misalign (1 bit, reset 0);
  - misaligned means a half access with a[0] = 1, or a word access with a[1:0] != 0;
  - a misaligned store is suppressed;
  - a misaligned load sets o_read_data to 0 and o_regWrite to 0;
  - o_misalign sets sticky and clears only on reset.
- Undefined: misaligned accesses proceed byte-wise with wrap, as described above; no o_misalign port.

Test Plan:
- Store word 0x12345678 at 0x10, then load word from 0x10: o_read_data = 0x12345678 one cycle later; byte load at 0x10 returns 0x00000078.
- Store byte 0x80 at 0x21; signed byte load returns 0xFFFFFF80; unsigned byte load returns 0x00000080.
- Store half 0xBEEF at 0x30; signed half load returns 0xFFFFBEEF; unsigned half load returns 0x0000BEEF.
- Hold i_stall for 3 cycles with memWrite set: outputs frozen, one write only; with i_halt set, a store of 0xDEADBEEF leaves memory unchanged.
- With i_halt set, i_dbg_addr = 0x13: o_dbg_data = word at 0x10 next cycle. Word store at 0xFE wraps into bytes 0xFE, 0xFF, 0x00, 0x01.
- Assert i_rst_n low mid-stream: outputs are 0 immediately (asynchronously); earlier stored data is still readable after release. With MISALIGN_TRAP_EN, a word load at 0x02 raises o_misalign and forces o_regWrite = 0.
